// File: rtl/mux_pipe.sv
// Registered N-channel mux with a one-deep valid/ready output stage.
// Optional round-robin arbitration is compiled in with `define MUX_RR_EN.
module mux_pipe #(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  localparam int SELW  = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 c,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] i,
  input  logic [NCH-1:0]       in_valid,
  input  logic [SELW-1:0]      sel,
  input  logic                 en,
`ifdef MUX_RR_EN
  input  logic                 mode,
`endif
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             take;

  assign in_ready  = !out_valid_q || out_ready;
  assign take      = en && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

  // Explicit select; sel values beyond NCH-1 leave sel_hit low.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        sel_hit  = 1'b1;
        sel_data = i[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUX_RR_EN
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  rr_next;
  logic [WIDTH-1:0] rr_data;
  int               rr_dist;
  int               rr_best;

  // Grant the valid channel with the smallest cyclic distance from rr_ptr.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_next  = '0;
    rr_data  = '0;
    rr_dist  = 0;
    rr_best  = NCH;
    for (int k = 0; k < NCH; k++) begin
      rr_dist = k - int'(rr_ptr_q);
      if (rr_dist < 0) rr_dist = rr_dist + NCH;
      if (in_valid[k] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_found = 1'b1;
        rr_idx   = SELW'(k);
        rr_next  = (k == NCH - 1) ? '0 : SELW'(k + 1);
        rr_data  = i[k*WIDTH +: WIDTH];
      end
    end
  end
`endif

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
`ifdef MUX_RR_EN
    rr_ptr_d    = rr_ptr_q;
    if (mode) begin
      if (take && rr_found) begin
        out_d       = rr_data;
        out_valid_d = 1'b1;
        out_ch_d    = rr_idx;
        rr_ptr_d    = rr_next;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end else
`endif
    if (take) begin
      if (sel_hit) begin
        out_d       = sel_data;
        out_valid_d = in_valid[sel];
        out_ch_d    = sel;
      end else begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
`ifdef MUX_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
`ifdef MUX_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// Bench for mux_pipe: directed table, stall/reset sequences, NCH=3 out-of-range
// select, optional round-robin sequences, and randomized checking against a model.
module tb_mux_pipe;

  logic         c = 1'b0;
  logic         rst;
  logic [127:0] i;
  logic [3:0]   iv;
  logic [1:0]   sel;
  logic         en;
  logic         rdy;
  logic         mode;
  logic         in_ready;
  logic [31:0]  out;
  logic         out_valid;
  logic [1:0]   out_ch;

  logic [23:0]  i3;
  logic [2:0]   iv3;
  logic [1:0]   sel3;
  logic         en3;
  logic         rdy3;
  logic         mode3;
  logic         in_ready3;
  logic [7:0]   out3;
  logic         out_valid3;
  logic [1:0]   out_ch3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 c = ~c;

  mux_pipe #(.WIDTH(32), .NCH(4)) u_dut (
    .c(c), .rst(rst), .i(i), .in_valid(iv), .sel(sel), .en(en),
`ifdef MUX_RR_EN
    .mode(mode),
`endif
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ch(out_ch),
    .out_ready(rdy)
  );

  mux_pipe #(.WIDTH(8), .NCH(3)) u_dut3 (
    .c(c), .rst(rst), .i(i3), .in_valid(iv3), .sel(sel3), .en(en3),
`ifdef MUX_RR_EN
    .mode(mode3),
`endif
    .in_ready(in_ready3), .out(out3), .out_valid(out_valid3), .out_ch(out_ch3),
    .out_ready(rdy3)
  );

  typedef struct {
    logic [3:0]  iv;
    logic [1:0]  sel;
    logic        en;
    logic        rdy;
    logic [31:0] e_out;
    logic        e_v;
    logic [1:0]  e_ch;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Behavioural reference: one clock edge of the output stage.
  task automatic model_step(input int nch, input int w, input logic [511:0] data,
                            input logic [15:0] v, input int s, input bit e, input bit r,
                            input bit m, inout logic [31:0] mo, inout bit mv,
                            inout int mc, inout int mp);
    logic [31:0] mask;
    bit ready;
    bit found;
    int k;
    mask  = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    ready = !mv || r;
    if (e && ready && m) begin
      found = 0;
      for (int o = 0; o < nch && !found; o++) begin
        k = (mp + o) % nch;
        if (v[k]) begin
          found = 1;
          mo = 32'(data >> (k * w)) & mask;
          mv = 1;
          mc = k;
          mp = (k + 1) % nch;
        end
      end
      if (!found && mv && r) mv = 0;
    end else if (e && ready) begin
      if (s < nch) begin
        mo = 32'(data >> (s * w)) & mask;
        mv = v[s];
        mc = s;
      end else begin
        mo = 0;
        mv = 0;
      end
    end else if (mv && r) begin
      mv = 0;
    end
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  logic [31:0] m_out, m3_out;
  bit          m_v, m3_v;
  int          m_ch, m_ptr, m3_ch, m3_ptr;
  logic [31:0] snap;

  initial begin
    rst = 1'b1;
    i = '0; iv = '0; sel = '0; en = 0; rdy = 0; mode = 0;
    i3 = '0; iv3 = '0; sel3 = '0; en3 = 0; rdy3 = 0; mode3 = 0;

    tbl[0] = '{4'b0100, 2'd2, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 2'd2};
    tbl[1] = '{4'b0100, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'd2};
    tbl[2] = '{4'b0001, 2'd0, 1'b1, 1'b0, 32'h11111111, 1'b1, 2'd0};
    tbl[3] = '{4'b1111, 2'd3, 1'b1, 1'b0, 32'h11111111, 1'b1, 2'd0};
    tbl[4] = '{4'b1111, 2'd3, 1'b1, 1'b1, 32'h44444444, 1'b1, 2'd3};
    tbl[5] = '{4'b0000, 2'd1, 1'b1, 1'b1, 32'h22222222, 1'b0, 2'd1};
    tbl[6] = '{4'b0000, 2'd1, 1'b0, 1'b0, 32'h22222222, 1'b0, 2'd1};
    tbl[7] = '{4'b0010, 2'd1, 1'b1, 1'b0, 32'h22222222, 1'b1, 2'd1};
    tbl[8] = '{4'b0010, 2'd2, 1'b0, 1'b0, 32'h22222222, 1'b1, 2'd1};
    tbl[9] = '{4'b0100, 2'd2, 1'b0, 1'b1, 32'h22222222, 1'b0, 2'd1};

    #3;
    check("reset_out", out, 32'h0);
    check("reset_valid", out_valid, 1'b0);
    check("reset_ch", out_ch, 2'd0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out3", out3, 8'h0);
    #4 rst = 1'b0;

    // Directed table, explicit select, starting from the idle state.
    i = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    for (int n = 0; n < 10; n++) begin
      iv = tbl[n].iv; sel = tbl[n].sel; en = tbl[n].en; rdy = tbl[n].rdy;
      tick();
      check($sformatf("tbl%0d_out", n), out, tbl[n].e_out);
      check($sformatf("tbl%0d_valid", n), out_valid, tbl[n].e_v);
      check($sformatf("tbl%0d_ch", n), out_ch, tbl[n].e_ch);
    end

    // Capture then stall for three cycles with en held high.
    i[95:64] = 32'hCAFEF00D;
    iv = 4'b0100; sel = 2'd2; en = 1; rdy = 0;
    #1 check("stall_pre_ready", in_ready, 1'b1);
    tick();
    check("stall_cap_out", out, 32'hCAFEF00D);
    check("stall_cap_valid", out_valid, 1'b1);
    i[31:0] = 32'h0BADC0DE;
    iv = 4'b0001; sel = 2'd0;
    for (int n = 0; n < 3; n++) begin
      #1 check($sformatf("stall%0d_in_ready", n), in_ready, 1'b0);
      tick();
      check($sformatf("stall%0d_out", n), out, 32'hCAFEF00D);
      check($sformatf("stall%0d_valid", n), out_valid, 1'b1);
      check($sformatf("stall%0d_ch", n), out_ch, 2'd2);
    end
    rdy = 1;
    #1 check("release_in_ready", in_ready, 1'b1);
    tick();
    check("release_out", out, 32'h0BADC0DE);
    check("release_valid", out_valid, 1'b1);
    check("release_ch", out_ch, 2'd0);

    // Asynchronous reset in the middle of a stall.
    en = 0; rdy = 0;
    tick();
    check("prerst_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", out, 32'h0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ch", out_ch, 2'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    #2 rst = 1'b0;
    iv = 4'b0010; sel = 2'd1; en = 1; rdy = 0;
    tick();
    check("postrst_out", out, 32'h22222222);
    check("postrst_valid", out_valid, 1'b1);
    check("postrst_ch", out_ch, 2'd1);
    en = 0;

    // NCH=3: out-of-range select clears the word and keeps out_ch.
    i3 = {8'h33, 8'h22, 8'h11};
    iv3 = 3'b010; sel3 = 2'd1; en3 = 1; rdy3 = 1;
    tick();
    check("n3_cap_out", out3, 8'h22);
    check("n3_cap_valid", out_valid3, 1'b1);
    check("n3_cap_ch", out_ch3, 2'd1);
    iv3 = 3'b111; sel3 = 2'd3;
    tick();
    check("n3_oor_out", out3, 8'h00);
    check("n3_oor_valid", out_valid3, 1'b0);
    check("n3_oor_ch", out_ch3, 2'd1);
    en3 = 0;

`ifdef MUX_RR_EN
    // Round-robin over in_valid=1011, then an empty request.
    pulse_reset();
    i = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    mode = 1; iv = 4'b1011; sel = 2'd2; en = 1; rdy = 1;
    begin
      logic [1:0]  exp_ch [4];
      logic [31:0] exp_d  [4];
      exp_ch = '{2'd0, 2'd1, 2'd3, 2'd0};
      exp_d  = '{32'h11111111, 32'h22222222, 32'h44444444, 32'h11111111};
      for (int n = 0; n < 4; n++) begin
        tick();
        check($sformatf("rr%0d_ch", n), out_ch, exp_ch[n]);
        check($sformatf("rr%0d_out", n), out, exp_d[n]);
        check($sformatf("rr%0d_valid", n), out_valid, 1'b1);
      end
    end
    iv = 4'b0000;
    tick();
    check("rr_empty_valid", out_valid, 1'b0);
    check("rr_empty_ch", out_ch, 2'd0);
    check("rr_empty_out", out, 32'h11111111);
    iv = 4'b1111;
    tick();
    check("rr_ptr_held_ch", out_ch, 2'd1);
    mode = 0; en = 0;
`endif

    // Randomized run against the reference model on both instances.
    pulse_reset();
    m_out = 0; m_v = 0; m_ch = 0; m_ptr = 0;
    m3_out = 0; m3_v = 0; m3_ch = 0; m3_ptr = 0;
    for (int n = 0; n < 400; n++) begin
      i   = {$urandom, $urandom, $urandom, $urandom};
      iv  = 4'($urandom_range(0, 15));
      sel = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      i3   = 24'($urandom);
      iv3  = 3'($urandom_range(0, 7));
      sel3 = 2'($urandom_range(0, 3));
      en3  = ($urandom_range(0, 3) != 0);
      rdy3 = 1'($urandom_range(0, 1));
`ifdef MUX_RR_EN
      mode  = 1'($urandom_range(0, 1));
      mode3 = 1'($urandom_range(0, 1));
`endif
      #1;
      check("rnd_in_ready_pre", in_ready, !m_v || rdy);
      model_step(4, 32, {384'b0, i}, {12'b0, iv}, int'(sel), en, rdy, mode,
                 m_out, m_v, m_ch, m_ptr);
      model_step(3, 8, {488'b0, i3}, {13'b0, iv3}, int'(sel3), en3, rdy3, mode3,
                 m3_out, m3_v, m3_ch, m3_ptr);
      tick();
      check("rnd_out", out, m_out);
      check("rnd_valid", out_valid, m_v);
      check("rnd_ch", out_ch, m_ch[1:0]);
      check("rnd3_out", out3, m3_out);
      check("rnd3_valid", out_valid3, m3_v);
      check("rnd3_ch", out_ch3, m3_ch[1:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel.
REQ-002 SHALL have parameter NCH, default 4, range 2..16: number of input channels.
REQ-003 SHALL derive localparam SELW = clog2(NCH), minimum 1.
REQ-004 SHALL have port c, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i, input, NCH*WIDTH bits: packed channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, NCH bits: per-channel valid.
REQ-008 SHALL have port sel, input, SELW bits: explicit channel select.
REQ-009 SHALL have port en, input, 1 bit: capture request.
REQ-010 SHALL have port in_ready, output, 1 bit: combinational, equal to !out_valid || out_ready.
REQ-011 SHALL have port out, output, WIDTH bits: registered selected data.
REQ-012 SHALL have port out_valid, output, 1 bit: registered, qualifies out.
REQ-013 SHALL have port out_ch, output, SELW bits: registered index of the captured channel.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-015 SHALL have port mode, input, 1 bit, present only when MUX_RR_EN is defined: 0 = explicit select, 1 = round-robin.

Function
REQ-016 SHALL define a capture as a rising edge of c with en=1 and in_ready=1; latency from i/sel to out is exactly 1 cycle.
REQ-017 On an explicit-select capture with sel<NCH, the block SHALL load out <= channel sel, out_valid <= in_valid[sel], and out_ch <= sel.
REQ-018 On a capture with sel>=NCH (non-power-of-2 NCH), the block SHALL load out <= 0 and out_valid <= 0, and leave out_ch unchanged.
REQ-019 On an edge with no capture, if out_valid=1 and out_ready=1 the block SHALL clear out_valid, and out and out_ch SHALL retain their values.
REQ-020 On an edge with no capture, if out_valid=1 and out_ready=0 (stall), out, out_valid and out_ch SHALL all hold.
REQ-021 Simultaneous out_ready=1 and capture SHALL act as a capture: the new word replaces the old, with no bubble.
REQ-022 The output register SHALL change only on a capture, on the clearing edge of REQ-019, or on reset.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force out=0, out_valid=0, out_ch=0 and rr_ptr=0, regardless of c.
REQ-024 A reset asserted mid-stall SHALL discard the held word; the first capture after reset deassertion SHALL behave as if from the idle state.
REQ-025 in_ready SHALL read 1 while rst=1.

Configuration
REQ-026 When macro MUX_RR_EN is defined, the block SHALL add port mode and an SELW-bit round-robin pointer rr_ptr.
REQ-027 With MUX_RR_EN and mode=1, sel SHALL be ignored; the granted channel SHALL be the first k with in_valid[k]=1, searching cyclically from rr_ptr.
REQ-028 With MUX_RR_EN, on a round-robin capture with a grant, the block SHALL load out <= channel k, out_valid <= 1 and out_ch <= k, and set rr_ptr <= (k+1) mod NCH.
REQ-029 With MUX_RR_EN, mode=1, en=1 and no in_valid bit set, the block SHALL not capture, out_valid SHALL follow REQ-019/REQ-020, and rr_ptr SHALL hold.
REQ-030 With MUX_RR_EN and mode=0, behaviour SHALL be identical to explicit select and rr_ptr SHALL hold.
REQ-031 Without MUX_RR_EN, port mode and rr_ptr SHALL be absent and only explicit select SHALL exist.

Verification
REQ-032 Bench SHALL cover this scenario: WIDTH=32, NCH=4, ch2=0xDEADBEEF, in_valid=4'b0100, sel=2, en=1, out_ready=1 -> next edge out=0xDEADBEEF, out_valid=1, out_ch=2.
REQ-033 Bench SHALL cover this scenario: hold out_ready=0 for 3 cycles after a capture with en=1 -> in_ready=0, out stable; raise out_ready -> captures the new word on the same edge.
REQ-034 Bench SHALL cover this scenario: NCH=3, sel=3, en=1 -> out=0, out_valid=0.
REQ-035 Bench SHALL cover this scenario: assert rst between edges while out_valid=1 -> out=0, out_valid=0, out_ch=0 before the next edge of c.
REQ-036 Bench SHALL cover this scenario: MUX_RR_EN, mode=1, in_valid=4'b1011, en=1, out_ready=1 for 4 cycles -> out_ch sequence 0,1,3,0.
REQ-037 Bench SHALL cover this scenario: MUX_RR_EN, mode=1, in_valid=0, en=1 -> no capture, rr_ptr unchanged, out_valid clears after the accept.
